// File: rtl/serial_link_pkg.sv
// Serial link constants shared by the enqueue and dequeue sides of the block framing.
package serial_link_pkg;

  // Each block carries one control bit; a set control bit marks the first block of a message.
  localparam int unsigned CtrlBitPos = 0;
  localparam logic        CtrlStart  = 1'b1;

endpackage

// File: rtl/lzc.sv
// Leading/trailing zero counter: MODE=0 counts trailing zeros, MODE=1 leading zeros.
module lzc #(
  parameter int unsigned WIDTH = 2,
  parameter bit          MODE  = 1'b0,
  localparam int unsigned CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0]     in_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 empty_o
);

  always_comb begin
    cnt_o = '0;
    if (MODE) begin
      for (int i = 0; i < int'(WIDTH); i++)
        if (in_i[i]) cnt_o = CNT_WIDTH'(int'(WIDTH) - 1 - i);
    end else begin
      for (int i = int'(WIDTH) - 1; i >= 0; i--)
        if (in_i[i]) cnt_o = CNT_WIDTH'(i);
    end
  end

  assign empty_o = ~|in_i;

endmodule

// File: rtl/dequeue_shift_register.sv
// Splits a packed multi-block word into messages delimited by per-block start bits,
// emitting one message per cycle lowest block first.
module dequeue_shift_register
  import serial_link_pkg::*;
#(
  parameter int unsigned ClkDiv                    = 1,
  parameter int unsigned MaxPossibleTransferSplits = 1,
  parameter type         data_block_t              = logic,
  parameter type         data_out_t                = logic,
  localparam int unsigned NumDatBlocks = ClkDiv * MaxPossibleTransferSplits,
  localparam int unsigned BlockSize    = $bits(data_block_t),
  localparam int unsigned CntW         = $clog2(NumDatBlocks + 1)
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic                                     valid_i,
  output logic                                     ready_o,
  input  logic [$bits(data_out_t)+NumDatBlocks-1:0] data_i,
  output logic                                     valid_o,
  input  logic                                     ready_i,
  output data_out_t                                data_o,
  output logic [CntW-1:0]                          blocks_o,
  output logic                                     err_o
);

  localparam int unsigned PayW = BlockSize - 1;
  localparam int unsigned IdxW = (NumDatBlocks > 1) ? $clog2(NumDatBlocks) : 1;

  typedef logic [$bits(data_out_t)+NumDatBlocks-1:0] data_in_t;
  typedef logic [CntW-1:0]                           block_cntr_t;
  typedef logic [NumDatBlocks-1:0][PayW-1:0]         payload_t;

  if (BlockSize < 2) begin : g_bad_block
    $fatal(1, "data_block_t needs at least one payload bit besides the control bit");
  end
  if ($bits(data_out_t) != NumDatBlocks * PayW) begin : g_bad_out
    $fatal(1, "data_out_t width must equal NumDatBlocks*(BlockSize-1)");
  end

  payload_t                word_q, payload_in, shifted, out_pay;
  logic [NumDatBlocks-1:0] pend_q, pend_hi, ctrl;
  logic                    err_q;
  logic [IdxW-1:0]         s_idx, e_idx;
  logic                    s_empty, e_empty;
  block_cntr_t             e_blk, blk_cnt;
  data_in_t                din;
  logic                    accept, retire;

  // Separate control bits from payload; payload bits keep their order within each block.
  assign din = data_i;
  always_comb begin
    ctrl       = '0;
    payload_in = '0;
    for (int i = 0; i < int'(NumDatBlocks); i++) begin
      ctrl[i] = (din[i*BlockSize + CtrlBitPos] == CtrlStart);
      for (int j = 0; j < int'(PayW); j++)
        payload_in[i][j] = din[i*BlockSize + ((j < int'(CtrlBitPos)) ? j : j + 1)];
    end
  end

  lzc #(.WIDTH(NumDatBlocks), .MODE(1'b0)) u_lzc_start (
    .in_i    (pend_q),
    .cnt_o   (s_idx),
    .empty_o (s_empty)
  );

  always_comb begin
    pend_hi        = pend_q;
    pend_hi[s_idx] = 1'b0;
  end

  lzc #(.WIDTH(NumDatBlocks), .MODE(1'b0)) u_lzc_end (
    .in_i    (pend_hi),
    .cnt_o   (e_idx),
    .empty_o (e_empty)
  );

  assign valid_o  = ~s_empty;
  assign e_blk    = e_empty ? block_cntr_t'(NumDatBlocks) : block_cntr_t'(e_idx);
  assign blk_cnt  = e_blk - block_cntr_t'(s_idx);
  assign blocks_o = valid_o ? blk_cnt : '0;
  assign retire   = valid_o & ready_i;
  // Reload is allowed in the same cycle the final pending message leaves.
  assign ready_o  = ~valid_o | (ready_i & e_empty);
  assign accept   = valid_i & ready_o;
  assign err_o    = err_q;

  assign shifted = word_q >> (int'(s_idx) * PayW);
  always_comb begin
    out_pay = '0;
    for (int i = 0; i < int'(NumDatBlocks); i++)
      if (valid_o && (block_cntr_t'(i) < blk_cnt)) out_pay[i] = shifted[i];
  end
  assign data_o = data_out_t'(out_pay);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q <= '0;
      word_q <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= accept & ~ctrl[0];
      if (accept) begin
        pend_q <= ctrl[0] ? ctrl : '0;
        if (ctrl[0]) word_q <= payload_in;
      end else if (retire) begin
        pend_q <= pend_hi;
      end
    end
  end

endmodule
